// File: rtl/perceptron_mac_seq.sv
// perceptron_mac_seq: sequential perceptron dot-product engine.
// Fetches N_INPUTS x/w pairs and feeds an external combinational multiplier.
// It accumulates the products onto a sign-extended bias.
// The result is held on a valid/ready handshake.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, bias                request a dot product, 32-bit signed bias
//   busy                       high whenever not IDLE
//   mem_rd_en, mem_addr        pair fetch strobe and index
//   mem_x, mem_w               fetched pair, one cycle after mem_rd_en
//   mul_a, mul_b, mul_r        registered multiplier operands and product
//   res_valid, res_ready       result handshake
//   acc_out, y                 accumulated sum and sign-based output
module perceptron_mac_seq #(
    parameter int N_INPUTS = 8,
    parameter int IDX_W    = 4,
    parameter int ACC_W    = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       bias,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [IDX_W-1:0]  mem_addr,
    input  logic [15:0]       mem_x,
    input  logic [31:0]       mem_w,
    output logic [15:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [47:0]       mul_r,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drain_q, drain_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;
    // v1: a fetched pair sits on mem_x/mem_w this cycle.
    // v2: mul_a/mul_b hold a fetched pair, so mul_r is a real product.
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;

    logic [ACC_W-1:0] bias_ext;
    logic [ACC_W-1:0] prod_ext;

    assign bias_ext = {{(ACC_W-32){bias[31]}}, bias};
    assign prod_ext = {{(ACC_W-48){mul_r[47]}}, mul_r};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        acc_d   = acc_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        v1_d    = (state_q == RUN);
        v2_d    = v1_q;

        if (v1_q) begin
            mul_a_d = mem_x;
            mul_b_d = mem_w;
        end

        // Wrapping two's-complement accumulate of a valid product.
        if (v2_q) begin
            acc_d = acc_q + prod_ext;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    acc_d   = bias_ext;
                end
            end
            RUN: begin
                if (idx_q == LAST) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    drain_d = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            // Two cycles let the last pair pass the
            // operand register and the accumulator.
            DRAIN: begin
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= 1'b0;
            acc_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            acc_q   <= acc_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_rd_en = (state_q == RUN);
    assign mem_addr  = idx_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign y         = ~acc_q[ACC_W-1];

endmodule

// File: tb/tb_perceptron_mac_seq.sv
// Directed testbench for perceptron_mac_seq.
// Default instance plus an N_INPUTS=1 instance.
module tb_perceptron_mac_seq;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic        busy, mem_rd_en, res_valid, y;
    logic [3:0]  mem_addr;
    logic [15:0] mem_x = '0;
    logic [31:0] mem_w = '0;
    logic [15:0] mul_a;
    logic [31:0] mul_b;
    logic [47:0] mul_r;
    logic        res_ready = 1'b1;
    logic [55:0] acc_out;

    logic        start1 = 1'b0;
    logic [31:0] bias1 = '0;
    logic        busy1, rd1, valid1, y1;
    logic [3:0]  addr1;
    logic [15:0] mx1 = '0;
    logic [31:0] mw1 = '0;
    logic [15:0] ma1;
    logic [31:0] mb1;
    logic [47:0] mr1;
    logic        ready1 = 1'b1;
    logic [55:0] acc1;

    logic [15:0] xm [0:15];
    logic [31:0] wm [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    perceptron_mac_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_x(mem_x), .mem_w(mem_w), .mul_a(mul_a), .mul_b(mul_b),
        .mul_r(mul_r), .res_valid(res_valid), .res_ready(res_ready),
        .acc_out(acc_out), .y(y)
    );

    perceptron_mac_seq #(.N_INPUTS(1)) u_one (
        .clk(clk), .rst(rst), .start(start1), .bias(bias1),
        .busy(busy1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_x(mx1), .mem_w(mw1), .mul_a(ma1), .mul_b(mb1),
        .mul_r(mr1), .res_valid(valid1), .res_ready(ready1),
        .acc_out(acc1), .y(y1)
    );

    assign mul_r = 48'($signed({{32{mul_a[15]}}, mul_a})
                     * $signed({{16{mul_b[31]}}, mul_b}));
    assign mr1   = 48'($signed({{32{ma1[15]}}, ma1})
                     * $signed({{16{mb1[31]}}, mb1}));

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_x <= xm[mem_addr];
            mem_w <= wm[mem_addr];
        end
        if (rd1) begin
            mx1 <= 16'd7;
            mw1 <= 32'd9;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_ones();
        for (int k = 0; k < 16; k++) begin
            xm[k] = 16'd1;
            wm[k] = 32'd2;
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) begin
            xm[k] = 16'(k + 1);
            wm[k] = 32'd3;
        end
    endtask

    // Single start pulse in cycle 0, res_ready=1 throughout.
    task automatic run_basic(input logic [31:0] b,
                             input logic [63:0] eacc,
                             input logic ey);
        bias = b;
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk("rd_en", 64'(mem_rd_en), 64'(c <= N));
            if (c <= N) chk("addr", 64'(mem_addr), 64'(c - 1));
            chk("valid", 64'(res_valid), 64'(c == N + 3));
            chk("busy", 64'(busy), 64'(c <= N + 3));
            if (c == N + 3) begin
                chk("acc", 64'($signed(acc_out)), eacc);
                chk("y", 64'(y), 64'(ey));
            end
            tick();
        end
    endtask

    initial begin
        load_ones();
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);

        // Start in the first cycle after reset release.
        rst = 1'b0;
        run_basic(32'd0, 64'd16, 1'b1);
        run_basic(-32'sd20, -64'sd4, 1'b0);

        // Back-pressure with ignored start pulses.
        load_ramp();
        bias = 32'd5;
        res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("bp_valid_lo", 64'(res_valid), 64'd0);
            tick();
        end
        for (int c = 11; c <= 16; c++) begin
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_acc", 64'($signed(acc_out)), 64'd113);
            chk("bp_y", 64'(y), 64'd1);
            start = 1'b1;
            tick();
        end
        chk("bp_valid_last", 64'(res_valid), 64'd1);
        chk("bp_acc_last", 64'($signed(acc_out)), 64'd113);
        res_ready = 1'b1;
        tick();
        chk("bp_idle_busy", 64'(busy), 64'd0);
        chk("bp_idle_valid", 64'(res_valid), 64'd0);
        start = 1'b0;
        tick();
        chk("bp_no_queue", 64'(busy), 64'd0);

        // Mid-run reset.
        load_ones();
        bias = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_valid", 64'(res_valid), 64'd0);
        chk("mr_acc", 64'(acc_out), 64'd0);
        chk("mr_rd_en", 64'(mem_rd_en), 64'd0);
        rst = 1'b0;
        run_basic(32'd0, 64'd16, 1'b1);

        // start held high: back-to-back runs 12 cycles apart.
        load_ramp();
        bias = 32'd5;
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 24; c++) begin
            chk("b2b_rd_en", 64'(mem_rd_en),
                64'((c >= 1 && c <= 8) || (c >= 13 && c <= 20)));
            if (c <= 8) chk("b2b_addr", 64'(mem_addr), 64'(c - 1));
            if (c >= 13 && c <= 20)
                chk("b2b_addr", 64'(mem_addr), 64'(c - 13));
            chk("b2b_valid", 64'(res_valid), 64'(c == 11 || c == 23));
            if (c == 11 || c == 23)
                chk("b2b_acc", 64'($signed(acc_out)), 64'd113);
            if (c == 12) chk("b2b_gap", 64'(busy), 64'd0);
            if (c == 24) start = 1'b0;
            tick();
        end
        chk("b2b_end", 64'(busy), 64'd0);

        // Single-pair instance.
        bias1 = -32'sd63;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("n1_rd_en", 64'(rd1), 64'(c == 1));
            chk("n1_valid", 64'(valid1), 64'(c == 4));
            if (c == 4) begin
                chk("n1_acc", 64'($signed(acc1)), 64'd0);
                chk("n1_y", 64'(y1), 64'd1);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_mac_seq.md
PERCEPTRON_MAC_SEQ -- requirements
Module: perceptron_mac_seq

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 8: number of x/w pairs per dot product, legal range 1..15.
REQ-002 The block SHALL have parameter IDX_W, default 4: width of the address/index, wide enough for N_INPUTS-1.
REQ-003 The block SHALL have parameter ACC_W, default 56: accumulator width, at least 48.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset, exactly as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have the following data and control ports:
- start  in  1  request one dot product; sampled only in IDLE.
- bias  in  32  signed; initial accumulator value.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  read strobe to the x/w storage.
- mem_addr  out  IDX_W  pair index.
- mem_x  in  16  signed input; valid one cycle after its mem_rd_en.
- mem_w  in  32  signed weight; valid one cycle after its mem_rd_en.
- mul_a  out  16  registered operand to the external combinational 16x32 multiplier.
- mul_b  out  32  registered operand to the same multiplier.
- mul_r  in  48  multiplier product; combinational from mul_a/mul_b.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- acc_out  out  ACC_W  signed accumulated sum.
- y  out  1  perceptron output; 1 when acc_out >= 0.

Function
REQ-006 The block SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-007 In IDLE with start=1, at the next edge the block SHALL enter RUN, set idx=0 and load acc with bias sign-extended to ACC_W.
REQ-008 With start accepted in cycle 0, the block SHALL issue index k in cycle k+1 (k=0..N_INPUTS-1), with mem_rd_en=1 and mem_addr=k.
REQ-009 The block SHALL hold mem_rd_en=0 outside RUN.
REQ-010 The block SHALL register mem_x/mem_w into mul_a/mul_b at the end of cycle k+2.
REQ-011 The block SHALL add mul_r, sign-extended to ACC_W, into acc at the end of cycle k+3.
REQ-012 The block SHALL perform accumulation in two's complement, wrapping modulo 2^ACC_W with no saturation.
REQ-013 The block SHALL suppress accumulation in every cycle whose mul_a/mul_b do not hold a fetched pair; a per-stage valid bit qualifies this.
REQ-014 After issuing index N_INPUTS-1, the block SHALL enter DRAIN for exactly 2 cycles, then enter DONE.
REQ-015 The first res_valid=1 cycle SHALL be cycle N_INPUTS+3 (cycle 11 at the defaults).
REQ-016 In DONE, the block SHALL hold res_valid=1 and keep acc_out/y stable until res_ready=1.
REQ-017 On DONE with res_ready=1, the block SHALL go to IDLE at the next edge and clear res_valid.
REQ-018 The block SHALL ignore start in RUN, DRAIN and DONE, including a DONE cycle in which res_ready=1; start is not queued.
REQ-019 A start accepted in IDLE SHALL cause res_valid=1 for exactly one result; res_valid SHALL never assert spontaneously.
REQ-020 The block SHALL drive y combinationally as ~acc_out[ACC_W-1].
REQ-021 The block SHALL drive acc_out directly from the acc register.
REQ-022 mul_a and mul_b SHALL hold their last value when no new pair is loaded.
REQ-023 When N_INPUTS=1, RUN SHALL last one cycle, with timing otherwise per REQ-008 to REQ-015.

Reset
REQ-024 With rst=1 at an edge, the block SHALL apply, at that edge: state=IDLE, idx=0, acc=0, mul_a=0, mul_b=0, pipeline valid bits=0, res_valid=0, mem_rd_en=0, mem_addr=0.
REQ-025 Reset SHALL take priority over start, res_ready and every state transition.
REQ-026 When asserted mid-operation, reset SHALL discard the partial sum, and no res_valid SHALL follow.
REQ-027 The block SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-028 Defaults, all x=1, w=2, bias=0, start in cycle 0, res_ready=1 -> mem_addr 0..7 in cycles 1..8; res_valid only in cycle 11; acc_out=16; y=1.
REQ-029 Same data, bias=-20 -> acc_out=-4; y=0.
REQ-030 x[k]=k+1, w[k]=3, bias=5, res_ready=0 for 6 cycles -> acc_out=113 held with res_valid=1 across those cycles; start pulses during them are ignored; IDLE one cycle after res_ready=1.
REQ-031 rst=1 in cycle 5 of a run -> next cycle busy=0, res_valid=0, acc_out=0, mem_rd_en=0; start in the following cycle runs a full, correct result.
REQ-032 start held high continuously, res_ready=1 -> back-to-back results 12 cycles apart; each acc_out correct; no overlap of mem_rd_en between runs.
REQ-033 N_INPUTS=1, x=7, w=9, bias=-63 -> res_valid first in cycle 4; acc_out=0; y=1.
